// File: rtl/tl_ul_slave_mem.sv
// tl_ul_slave_mem: TileLink-UL responder backed by a small register-array memory.
//   A channel (in):  a_valid, a_opcode, a_param, a_address, a_size, a_mask, a_data, a_source
//   A channel (out): a_ready
//   D channel (out): d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
//   D channel (in):  d_ready
//   clk rising edge; rst asynchronous active-low.
//   One transaction in flight: IDLE accepts, WAIT counts latency, RESP holds the D beat.
module tl_ul_slave_mem #(
    parameter int TL_ADDR_WIDTH   = 64,
    parameter int TL_DATA_WIDTH   = 64,
    parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
    parameter int TL_SOURCE_WIDTH = 3,
    parameter int TL_SINK_WIDTH   = 3,
    parameter int TL_OPCODE_WIDTH = 3,
    parameter int TL_PARAM_WIDTH  = 3,
    parameter int TL_SIZE_WIDTH   = 8,
    parameter int MEM_DEPTH       = 16,
    parameter int RESP_LATENCY    = 1,
    parameter int SINK_ID         = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [TL_OPCODE_WIDTH-1:0] a_opcode,
    input  logic [TL_PARAM_WIDTH-1:0]  a_param,
    input  logic [TL_ADDR_WIDTH-1:0]   a_address,
    input  logic [TL_SIZE_WIDTH-1:0]   a_size,
    input  logic [TL_STRB_WIDTH-1:0]   a_mask,
    input  logic [TL_DATA_WIDTH-1:0]   a_data,
    input  logic [TL_SOURCE_WIDTH-1:0] a_source,
    output logic                       d_valid,
    input  logic                       d_ready,
    output logic [TL_OPCODE_WIDTH-1:0] d_opcode,
    output logic [TL_PARAM_WIDTH-1:0]  d_param,
    output logic [TL_SIZE_WIDTH-1:0]   d_size,
    output logic [TL_SOURCE_WIDTH-1:0] d_source,
    output logic [TL_SINK_WIDTH-1:0]   d_sink,
    output logic [TL_DATA_WIDTH-1:0]   d_data,
    output logic                       d_error
);
    localparam int LW = $clog2(TL_STRB_WIDTH);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(RESP_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                       state_q;
    logic [CW-1:0]                cnt_q;
    logic [TL_DATA_WIDTH-1:0]     mem_q [MEM_DEPTH];
    logic                         a_ready_q;
    logic                         d_valid_q;
    logic [TL_OPCODE_WIDTH-1:0]   d_opcode_q;
    logic [TL_SIZE_WIDTH-1:0]     d_size_q;
    logic [TL_SOURCE_WIDTH-1:0]   d_source_q;
    logic [TL_DATA_WIDTH-1:0]     d_data_q;
    logic                         d_error_q;

    logic                         is_get, is_pf, is_pp, is_put;
    logic                         op_err, range_err, size_err, align_err, mask_err, err_d;
    logic [31:0]                  nbytes;
    logic [LW-1:0]                lo;
    logic [IW-1:0]                idx;
    logic [TL_STRB_WIDTH-1:0]     lane_mask;
    logic [TL_DATA_WIDTH-1:0]     rdata_d;
    logic                         unused_param;

    assign unused_param = ^a_param;

    // Request decode and error classification, evaluated on the A beat as presented.
    always_comb begin
        is_pf     = a_opcode == TL_OPCODE_WIDTH'(0);
        is_pp     = a_opcode == TL_OPCODE_WIDTH'(1);
        is_get    = a_opcode == TL_OPCODE_WIDTH'(4);
        is_put    = is_pf || is_pp;
        op_err    = !(is_put || is_get);
        lo        = a_address[LW-1:0];
        idx       = a_address[LW +: IW];
        range_err = |a_address[TL_ADDR_WIDTH-1:LW+IW];
        size_err  = a_size > TL_SIZE_WIDTH'(LW);
        nbytes    = size_err ? 32'd0 : 32'd1 << a_size;
        align_err = !size_err && ((32'(lo) & (nbytes - 32'd1)) != 32'd0);
        lane_mask = '0;
        for (int i = 0; i < TL_STRB_WIDTH; i++)
            lane_mask[i] = (32'(i) >= 32'(lo)) && (32'(i) < 32'(lo) + nbytes);
        mask_err  = (is_pf && a_mask != lane_mask) || (is_pp && |(a_mask & ~lane_mask));
        err_d     = op_err || range_err || size_err || align_err || mask_err;
        rdata_d   = (is_get && !err_d) ? mem_q[idx] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_ready_q  <= 1'b1;
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_data_q   <= '0;
            d_error_q  <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: if (a_valid) begin
                    d_opcode_q <= is_get ? TL_OPCODE_WIDTH'(1) : TL_OPCODE_WIDTH'(0);
                    d_size_q   <= a_size;
                    d_source_q <= a_source;
                    d_error_q  <= err_d;
                    d_data_q   <= rdata_d;
                    a_ready_q  <= 1'b0;
                    // PutFullData passes only with a_mask equal to the lane mask, so a
                    // per-lane write covers both Put kinds.
                    if (is_put && !err_d)
                        for (int i = 0; i < TL_STRB_WIDTH; i++)
                            if (a_mask[i])
                                mem_q[idx][8*i +: 8] <= a_data[8*i +: 8];
                    if (RESP_LATENCY == 1) begin
                        state_q   <= RESP;
                        d_valid_q <= 1'b1;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= CW'(RESP_LATENCY - 1);
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q   <= RESP;
                        d_valid_q <= 1'b1;
                    end
                end
                RESP: if (d_ready) begin
                    state_q   <= IDLE;
                    d_valid_q <= 1'b0;
                    a_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_ready  = a_ready_q;
    assign d_valid  = d_valid_q;
    assign d_opcode = d_opcode_q;
    assign d_param  = '0;
    assign d_size   = d_size_q;
    assign d_source = d_source_q;
    assign d_sink   = TL_SINK_WIDTH'(SINK_ID);
    assign d_data   = d_data_q;
    assign d_error  = d_error_q;
endmodule

// File: doc/tl_ul_slave_mem.md
Name: tl_ul_slave_mem

Overview:
- TileLink-UL responder (slave endpoint) backed by a small register-array memory.
- It sits behind the 1-master/3-slave crossbar as one of the slave ports.
- It accepts A-channel Get, PutFullData and PutPartialData requests and returns AccessAckData or AccessAck on the D channel after a programmable latency.
- Only one transaction is outstanding at a time; error checking covers opcode, range, alignment and mask.

Parameters:
TL_ADDR_WIDTH, 64, A-channel address width
TL_DATA_WIDTH, 64, data bus width (bits)
TL_STRB_WIDTH, TL_DATA_WIDTH/8, mask width (byte lanes)
TL_SOURCE_WIDTH, 3, source ID width
TL_SINK_WIDTH, 3, sink ID width
TL_OPCODE_WIDTH, 3, opcode width
TL_PARAM_WIDTH, 3, param width
TL_SIZE_WIDTH, 8, size field width (log2 bytes)
MEM_DEPTH, 16, number of data words (power of 2, >=2)
RESP_LATENCY, 1, cycles from A-beat acceptance to first d_valid (>=1)
SINK_ID, 0, constant driven on d_sink

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
a_valid  in  1  A request valid
a_ready  out  1  slave can accept A beat
a_opcode  in  TL_OPCODE_WIDTH  0=PutFullData, 1=PutPartialData, 4=Get
a_param  in  TL_PARAM_WIDTH  ignored, must be 0
a_address  in  TL_ADDR_WIDTH  byte address
a_size  in  TL_SIZE_WIDTH  log2 transfer bytes
a_mask  in  TL_STRB_WIDTH  byte-lane enables
a_data  in  TL_DATA_WIDTH  write data
a_source  in  TL_SOURCE_WIDTH  requester ID
d_valid  out  1  D response valid
d_ready  in  1  master accepts D beat
d_opcode  out  TL_OPCODE_WIDTH  0=AccessAck, 1=AccessAckData
d_param  out  TL_PARAM_WIDTH  always 0
d_size  out  TL_SIZE_WIDTH  echo of a_size
d_source  out  TL_SOURCE_WIDTH  echo of a_source
d_sink  out  TL_SINK_WIDTH  SINK_ID
d_data  out  TL_DATA_WIDTH  read data; 0 for AccessAck and for errored Get
d_error  out  1  denied/corrupt response

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE, latency counter clears to 0, all memory words clear to 0.
  - a_ready=1 once rst deasserts.
  - d_valid=0; d_opcode, d_param, d_size, d_source, d_data and d_error are 0; d_sink=SINK_ID.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - a_ready=1, d_valid=0.
  - An A beat is accepted on a rising edge where a_valid & a_ready.
  - On accept: latch opcode, size, source and error flag; perform the memory action.
  - Next state is RESP if RESP_LATENCY==1, else WAIT with counter=RESP_LATENCY-1.
- WAIT:
  - a_ready=0, d_valid=0.
  - Counter decrements each cycle; go to RESP when it reaches 1.
- RESP:
  - a_ready=0, d_valid=1; all d_* outputs are registered and stable while d_valid & !d_ready.
  - On d_valid & d_ready, return to IDLE; a_ready is 1 in the following cycle.
- Latency: first d_valid = RESP_LATENCY cycles after the accepting edge. Minimum back-to-back period is RESP_LATENCY+1 cycles with d_ready held high.
- Word index = a_address[log2(TL_STRB_WIDTH) +: log2(MEM_DEPTH)].
- Error conditions (any one sets d_error=1):
  - Opcode not in {0,1,4}.
  - a_address >= MEM_DEPTH*TL_STRB_WIDTH.
  - a_size > log2(TL_STRB_WIDTH).
  - Address not aligned to 2^a_size.
  - PutFullData with a_mask != lane mask implied by a_size and address low bits.
  - PutPartialData with any a_mask bit outside the implied lane mask.
- Errored requests never modify memory.
- Response opcode:
  - Get → AccessAckData.
  - Put (either kind) → AccessAck.
  - Unsupported opcode → AccessAck with d_error=1.
- Write: at the accepting edge, memory byte lane i is updated where a_mask[i]=1; other lanes are unchanged.
- Read: the full word is captured at the accepting edge, so a Put accepted earlier is always visible. A Get with error returns d_data=0.
- a_valid asserted while a_ready=0 is not accepted; the master must hold the beat, and no state changes.
- rst asserted mid-WAIT or mid-RESP aborts the transaction and drops d_valid immediately. A write already committed at the accepting edge stays committed until reset clears the memory.

Test Plan:
1. Reset, then PutFullData addr 0x0, size 3, mask 0xFF, data 0xDEADBEEF_CAFEBABE, source 0 → d_valid RESP_LATENCY cycles later with AccessAck, d_source=0, d_error=0.
2. Get addr 0x0, size 3, source 2 → AccessAckData, d_data=0xDEADBEEF_CAFEBABE, d_size=3, d_source=2.
3. PutPartialData addr 0x8, size 3, mask 0x0F, data 0x11111111_22222222 after a full write of 0xAAAAAAAA_BBBBBBBB; then Get 0x8 → d_data=0xAAAAAAAA_22222222.
4. Hold d_ready=0 for 5 cycles during RESP → d_valid stays 1, d_* unchanged, a_ready=0; response completes on the first cycle d_ready=1.
5. Get addr 0x80 with MEM_DEPTH=16, and PutFullData addr 0x4 size 3 → both return d_error=1; a Get of that word afterwards shows unchanged data. Opcode 2 returns AccessAck with d_error=1.
6. Assert rst=0 while in RESP → d_valid=0 immediately; after release, a_ready=1 and Get 0x0 returns 0.
